axi3_mem_responder: RTL and testbench

//  AXI3 slave memory model answering IP_Top's MAXI0 master port (64-bit data, 4-bit LEN) in the

---
 rtl/axi3_mem_pkg.sv | 23 ++
 rtl/axi3_mem_bank.sv | 33 +++
 rtl/axi3_mem_responder.sv | 216 +++++++++++++++++++++
 tb/tb_axi3_mem_responder.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi3_mem_pkg.sv
// Shared constants, FSM state types and the address-range helper for the
// AXI3 simulation memory responder.
package axi3_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] SIZE_8B     = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  // True when every beat of a len+1 beat, 8-byte INCR burst starting at addr
  // lands inside [base, base + 8*words). addr[2:0] does not matter.
  function automatic logic in_range(input logic [31:0] addr, input logic [3:0] len,
                                    input logic [31:0] base, input logic [31:0] words);
    logic [32:0] last_word;
    if (addr < base) return 1'b0;
    last_word = {1'b0, (addr - base) >> 3} + {29'b0, len};
    return last_word < {1'b0, words};
  endfunction

endpackage

// File: rtl/axi3_mem_bank.sv
// Storage array for the AXI3 memory responder: WORDS x 64-bit words, one
// asynchronous read port and one synchronous byte-enabled write port.
// Contents are never reset; a simulation environment may preload mem_q
// hierarchically.
//   clk_i     clock
//   raddr_i   read word index     rdata_o  read data (combinational)
//   we_i      write enable        waddr_i  write word index
//   wstrb_i   byte enables        wdata_i  write data
module axi3_mem_bank #(
  parameter int unsigned WORDS = 65536
) (
  input  logic                     clk_i,
  input  logic [$clog2(WORDS)-1:0] raddr_i,
  output logic [63:0]              rdata_o,
  input  logic                     we_i,
  input  logic [$clog2(WORDS)-1:0] waddr_i,
  input  logic [7:0]               wstrb_i,
  input  logic [63:0]              wdata_i
);

  logic [63:0] mem_q [WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (wstrb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi3_mem_responder.sv
// AXI3 slave memory model (64-bit data, 4-bit LEN). Independent read and
// write engines, one outstanding burst each, configurable read latency,
// byte-strobed writes, SLVERR for non-INCR / non-8-byte / out-of-range bursts.
//   IP_CLK, IP_ARESET_N           clock, async active-low reset
//   S_AR*/S_R*                    read address and read data channels
//   S_AW*/S_W*/S_B*               write address, data and response channels
module axi3_mem_responder
  import axi3_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int unsigned MEM_WORDS    = 65536,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic        IP_CLK,
  input  logic        IP_ARESET_N,
  input  logic [31:0] S_ARADDR,
  input  logic        S_ARVALID,
  output logic        S_ARREADY,
  input  logic [3:0]  S_ARLEN,
  input  logic [1:0]  S_ARSIZE,
  input  logic [1:0]  S_ARBURST,
  output logic [63:0] S_RDATA,
  output logic [1:0]  S_RRESP,
  output logic        S_RLAST,
  output logic        S_RVALID,
  input  logic        S_RREADY,
  input  logic [31:0] S_AWADDR,
  input  logic        S_AWVALID,
  output logic        S_AWREADY,
  input  logic [3:0]  S_AWLEN,
  input  logic [1:0]  S_AWSIZE,
  input  logic [1:0]  S_AWBURST,
  input  logic [63:0] S_WDATA,
  input  logic [7:0]  S_WSTRB,
  input  logic        S_WLAST,
  input  logic        S_WVALID,
  output logic        S_WREADY,
  output logic [1:0]  S_BRESP,
  output logic        S_BVALID,
  input  logic        S_BREADY
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(READ_LATENCY + 1);

  function automatic logic burst_ok(input logic [31:0] addr, input logic [3:0] len,
                                    input logic [1:0] size, input logic [1:0] burst);
    return (size == SIZE_8B) && (burst == BURST_INCR) &&
           in_range(addr, len, BASE_ADDR, 32'(MEM_WORDS));
  endfunction

  // Read engine state
  rd_state_t     rd_state_q;
  logic          arready_q, rvalid_q, rlast_q, rerr_q;
  logic [63:0]   rdata_q;
  logic [1:0]    rresp_q;
  logic [CW-1:0] rcnt_q;
  logic [3:0]    rbeat_q, rlen_q;
  logic [AW-1:0] ridx_q;

  // Write engine state
  wr_state_t     wr_state_q;
  logic          awready_q, wready_q, bvalid_q, werr_q, wmis_q;
  logic [1:0]    bresp_q;
  logic [3:0]    wbeat_q, wlen_q;
  logic [AW-1:0] widx_q;

  logic [AW-1:0] rd_word, wr_word;
  logic [63:0]   bank_rdata;
  logic          w_hs, bank_we, w_last_beat, wlast_bad;

  // The read port looks one beat ahead while bursting so the next beat's data
  // is ready to be registered on the current beat's handshake.
  always_comb begin
    rd_word = ridx_q + AW'(rbeat_q);
    if (rd_state_q == R_BURST) rd_word = rd_word + AW'(1);
  end

  assign wr_word     = widx_q + AW'(wbeat_q);
  assign w_hs        = wready_q && S_WVALID;
  assign bank_we     = w_hs && !werr_q;
  assign w_last_beat = (wbeat_q == wlen_q);
  assign wlast_bad   = (S_WLAST != w_last_beat);

  axi3_mem_bank #(.WORDS(MEM_WORDS)) u_bank (
    .clk_i   (IP_CLK),
    .raddr_i (rd_word),
    .rdata_o (bank_rdata),
    .we_i    (bank_we),
    .waddr_i (wr_word),
    .wstrb_i (S_WSTRB),
    .wdata_i (S_WDATA)
  );

  // Counter is loaded with READ_LATENCY-1 so that RVALID rises after exactly
  // READ_LATENCY idle cycles following the AR handshake.
  always_ff @(posedge IP_CLK or negedge IP_ARESET_N) begin
    if (!IP_ARESET_N) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rcnt_q     <= '0;
      rbeat_q    <= '0;
      rlen_q     <= '0;
      ridx_q     <= '0;
      rerr_q     <= 1'b0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (S_ARVALID) begin
            rd_state_q <= R_WAIT;
            arready_q  <= 1'b0;
            rcnt_q     <= CW'(READ_LATENCY - 1);
            rlen_q     <= S_ARLEN;
            rbeat_q    <= '0;
            ridx_q     <= AW'((S_ARADDR - BASE_ADDR) >> 3);
            rerr_q     <= !burst_ok(S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST);
          end
        end
        R_WAIT: begin
          if (rcnt_q == '0) begin
            rd_state_q <= R_BURST;
            rvalid_q   <= 1'b1;
            rdata_q    <= rerr_q ? '0 : bank_rdata;
            rresp_q    <= rerr_q ? RESP_SLVERR : RESP_OKAY;
            rlast_q    <= (rlen_q == 4'd0);
          end else begin
            rcnt_q <= rcnt_q - CW'(1);
          end
        end
        R_BURST: begin
          if (S_RREADY) begin
            if (rbeat_q == rlen_q) begin
              rd_state_q <= R_IDLE;
              rvalid_q   <= 1'b0;
              rlast_q    <= 1'b0;
              arready_q  <= 1'b1;
            end else begin
              rbeat_q <= rbeat_q + 4'd1;
              rdata_q <= rerr_q ? '0 : bank_rdata;
              rlast_q <= ((rbeat_q + 4'd1) == rlen_q);
            end
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // A WLAST mismatch only poisons the response; the burst still ends on beat
  // len and legal beats are still written.
  always_ff @(posedge IP_CLK or negedge IP_ARESET_N) begin
    if (!IP_ARESET_N) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      werr_q     <= 1'b0;
      wmis_q     <= 1'b0;
      wbeat_q    <= '0;
      wlen_q     <= '0;
      widx_q     <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (S_AWVALID) begin
            wr_state_q <= W_DATA;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wlen_q     <= S_AWLEN;
            wbeat_q    <= '0;
            wmis_q     <= 1'b0;
            widx_q     <= AW'((S_AWADDR - BASE_ADDR) >> 3);
            werr_q     <= !burst_ok(S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST);
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (w_last_beat) begin
              wr_state_q <= W_RESP;
              wready_q   <= 1'b0;
              bvalid_q   <= 1'b1;
              bresp_q    <= (werr_q || wmis_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              wbeat_q <= wbeat_q + 4'd1;
              wmis_q  <= wmis_q || wlast_bad;
            end
          end
        end
        W_RESP: begin
          if (S_BREADY) begin
            wr_state_q <= W_IDLE;
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  assign S_ARREADY = arready_q;
  assign S_RDATA   = rdata_q;
  assign S_RRESP   = rresp_q;
  assign S_RLAST   = rlast_q;
  assign S_RVALID  = rvalid_q;
  assign S_AWREADY = awready_q;
  assign S_WREADY  = wready_q;
  assign S_BRESP   = bresp_q;
  assign S_BVALID  = bvalid_q;

endmodule

// File: tb/tb_axi3_mem_responder.sv
// Self-checking bench for axi3_mem_responder: table-driven single-beat
// vectors, hand sequences for burst/stall/reset corners, and randomized
// bursts checked against a word-addressed reference memory.
module tb_axi3_mem_responder;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int unsigned WORDS  = 65536;
  localparam int unsigned RL     = 4;
  localparam int          BUDGET = 200;
  localparam logic [31:0] TOP    = BASE + 32'(8 * WORDS);

  logic        IP_CLK = 1'b0;
  logic        IP_ARESET_N;
  logic [31:0] S_ARADDR, S_AWADDR;
  logic        S_ARVALID, S_ARREADY, S_AWVALID, S_AWREADY;
  logic [3:0]  S_ARLEN, S_AWLEN;
  logic [1:0]  S_ARSIZE, S_ARBURST, S_AWSIZE, S_AWBURST;
  logic [63:0] S_RDATA, S_WDATA;
  logic [1:0]  S_RRESP, S_BRESP;
  logic        S_RLAST, S_RVALID, S_RREADY;
  logic [7:0]  S_WSTRB;
  logic        S_WLAST, S_WVALID, S_WREADY, S_BVALID, S_BREADY;

  axi3_mem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .READ_LATENCY(RL)) dut (
    .IP_CLK(IP_CLK), .IP_ARESET_N(IP_ARESET_N),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY)
  );

  always #5 IP_CLK = ~IP_CLK;

  typedef logic [63:0] dq_t [$];
  typedef logic [7:0]  sq_t [$];
  typedef logic [1:0]  rq_t [$];
  typedef logic        bq_t [$];

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [1:0]  burst;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [1:0]  exp_resp;
    logic [63:0] exp_rdata;
  } vec_t;

  int vecs = 0;
  int miscmp = 0;
  logic [63:0] mdl [int unsigned];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a, input int len,
                               input logic [1:0] sz, input logic [1:0] bt);
    longint off;
    if (sz != 2'b11 || bt != 2'b01) return 1'b0;
    off = longint'(a) - longint'(BASE);
    if (off < 0) return 1'b0;
    return (off / 8 + len) < longint'(WORDS);
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return (a - BASE) >> 3;
  endfunction

  function automatic void model_write(input logic [31:0] a, input int len, input logic [1:0] sz,
                                      input logic [1:0] bt, input dq_t d, input sq_t s);
    logic [63:0] cur;
    if (!legal(a, len, sz, bt)) return;
    for (int i = 0; i <= len; i++) begin
      cur = mdl.exists(widx(a) + i) ? mdl[widx(a) + i] : '0;
      for (int j = 0; j < 8; j++) if (s[i][j]) cur[8*j +: 8] = d[i][8*j +: 8];
      mdl[widx(a) + i] = cur;
    end
  endfunction

  function automatic logic rr_pat(input int mode, input int k);
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (mode == 2) return (k % 4 == 0) || (k % 4 == 3);
    return 1'b1;
  endfunction

  task automatic do_write(input logic [31:0] a, input int len, input logic [1:0] sz,
                          input logic [1:0] bt, input dq_t d, input sq_t s, input int lastbeat,
                          input bit rnd, input bit hold_b, output logic [1:0] bresp);
    int b, n;
    bit hs;
    bresp = 'x;
    @(posedge IP_CLK); #1;
    S_AWADDR = a; S_AWLEN = 4'(len); S_AWSIZE = sz; S_AWBURST = bt; S_AWVALID = 1'b1;
    n = 0;
    do begin
      @(negedge IP_CLK); hs = S_AWREADY; n++;
      @(posedge IP_CLK); #1;
    end while (!hs && n < BUDGET);
    S_AWVALID = 1'b0;
    check("aw_handshake", 64'(hs), 1);
    b = 0; n = 0;
    while (b <= len && n < BUDGET) begin
      S_WVALID = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      S_WDATA = d[b]; S_WSTRB = s[b]; S_WLAST = (b == lastbeat);
      @(negedge IP_CLK); hs = S_WVALID && S_WREADY; n++;
      @(posedge IP_CLK); #1;
      if (hs) b++;
    end
    S_WVALID = 1'b0; S_WLAST = 1'b0;
    check("w_beats", 64'(b), 64'(len + 1));
    n = 0; hs = 0;
    while (!hs && n < BUDGET) begin
      S_BREADY = hold_b ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      @(negedge IP_CLK); n++;
      if (S_BVALID) begin bresp = S_BRESP; hs = S_BREADY || hold_b; end
      @(posedge IP_CLK); #1;
    end
    S_BREADY = 1'b0;
    check("b_handshake", 64'(hs), 1);
  endtask

  task automatic do_read(input logic [31:0] a, input int len, input logic [1:0] sz,
                         input logic [1:0] bt, input int mode,
                         output dq_t rd, output rq_t rr, output bq_t rl, output int first);
    int n, k;
    bit hs, stalled;
    logic [63:0] held;
    rd = {}; rr = {}; rl = {}; first = -1; held = '0;
    @(posedge IP_CLK); #1;
    S_ARADDR = a; S_ARLEN = 4'(len); S_ARSIZE = sz; S_ARBURST = bt; S_ARVALID = 1'b1;
    n = 0;
    do begin
      @(negedge IP_CLK); hs = S_ARREADY; n++;
      @(posedge IP_CLK); #1;
    end while (!hs && n < BUDGET);
    S_ARVALID = 1'b0;
    check("ar_handshake", 64'(hs), 1);
    n = 0; k = 0; stalled = 0;
    S_RREADY = rr_pat(mode, k);
    while (rd.size() <= len && n < BUDGET) begin
      @(negedge IP_CLK); n++;
      if (stalled) begin
        check("r_stall_valid", 64'(S_RVALID), 1);
        check("r_stall_data", S_RDATA, held);
      end
      if (S_RVALID && first < 0) first = n;
      if (S_RVALID && S_RREADY) begin
        rd.push_back(S_RDATA); rr.push_back(S_RRESP); rl.push_back(S_RLAST);
        stalled = 0;
      end else if (S_RVALID) begin
        stalled = 1; held = S_RDATA;
      end
      @(posedge IP_CLK); #1;
      k++;
      S_RREADY = rr_pat(mode, k);
    end
    S_RREADY = 1'b0;
  endtask

  task automatic read_check(input string nm, input logic [31:0] a, input int len,
                            input logic [1:0] sz, input logic [1:0] bt, input int mode);
    dq_t rd; rq_t rr; bq_t rl;
    int first;
    bit lg;
    do_read(a, len, sz, bt, mode, rd, rr, rl, first);
    lg = legal(a, len, sz, bt);
    check({nm, "_beats"}, 64'(rd.size()), 64'(len + 1));
    check({nm, "_latency"}, 64'(first), 64'(RL + 1));
    for (int i = 0; i < rd.size(); i++) begin
      check({nm, "_data"}, rd[i], lg ? mdl[widx(a) + i] : 64'h0);
      check({nm, "_resp"}, 64'(rr[i]), lg ? 64'h0 : 64'h2);
      check({nm, "_last"}, 64'(rl[i]), 64'(i == len));
    end
    @(negedge IP_CLK);
    check({nm, "_no_extra_beat"}, 64'(S_RVALID), 0);
    check({nm, "_arready_back"}, 64'(S_ARREADY), 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp + 1);
    $fatal(1);
  end

  initial begin : main
    vec_t tbl[$];
    dq_t d, d2, rd; sq_t s, s2; rq_t rr; bq_t rl;
    logic [1:0] bresp, bresp2;
    logic [31:0] a;
    int len, first, n;

    IP_ARESET_N = 1'b0;
    S_ARADDR = '0; S_ARVALID = 0; S_ARLEN = '0; S_ARSIZE = '0; S_ARBURST = '0; S_RREADY = 0;
    S_AWADDR = '0; S_AWVALID = 0; S_AWLEN = '0; S_AWSIZE = '0; S_AWBURST = '0;
    S_WDATA = '0; S_WSTRB = '0; S_WLAST = 0; S_WVALID = 0; S_BREADY = 0;
    repeat (3) @(negedge IP_CLK);
    check("rst_arready", 64'(S_ARREADY), 1);
    check("rst_awready", 64'(S_AWREADY), 1);
    check("rst_rvalid", 64'(S_RVALID), 0);
    check("rst_rlast", 64'(S_RLAST), 0);
    check("rst_wready", 64'(S_WREADY), 0);
    check("rst_bvalid", 64'(S_BVALID), 0);
    check("rst_rdata", S_RDATA, 0);
    check("rst_rresp", 64'(S_RRESP), 0);
    check("rst_bresp", 64'(S_BRESP), 0);
    IP_ARESET_N = 1'b1;

    // Basic 4-beat write and read-back.
    d = {64'd1, 64'd2, 64'd3, 64'd4}; s = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_write(BASE, 3, 2'b11, 2'b01, d, s, 3, 0, 0, bresp);
    check("t1_bresp", 64'(bresp), 0);
    model_write(BASE, 3, 2'b11, 2'b01, d, s);
    read_check("t1_rd", BASE, 3, 2'b11, 2'b01, 0);

    // W beats presented before any AW are not accepted.
    @(posedge IP_CLK); #1;
    S_WVALID = 1'b1; S_WDATA = 64'hBAD; S_WSTRB = 8'hFF;
    repeat (2) begin
      @(negedge IP_CLK);
      check("w_before_aw", 64'(S_WREADY), 0);
    end
    @(posedge IP_CLK); #1; S_WVALID = 1'b0;

    // Single-beat table: strobes, ignored low address bits, legality edges.
    tbl.push_back('{BASE + 32'h40, 2'b11, 2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 2'b00, 64'hAAAA_AAAA_AAAA_AAAA});
    tbl.push_back('{BASE + 32'h40, 2'b11, 2'b01, 64'h1111_2222_3333_4444, 8'h0F, 2'b00, 64'hAAAA_AAAA_3333_4444});
    tbl.push_back('{BASE + 32'h45, 2'b11, 2'b01, 64'h5555_6666_7777_8888, 8'hF0, 2'b00, 64'h5555_6666_3333_4444});
    tbl.push_back('{BASE + 32'h40, 2'b10, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b10, 64'h0});
    tbl.push_back('{BASE + 32'h40, 2'b11, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b10, 64'h0});
    tbl.push_back('{BASE + 32'h40, 2'b11, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 2'b00, 64'h5555_6666_3333_4444});
    tbl.push_back('{BASE - 32'h8,  2'b11, 2'b01, 64'h1234_5678_9ABC_DEF0, 8'hFF, 2'b10, 64'h0});
    tbl.push_back('{TOP - 32'h8,   2'b11, 2'b01, 64'hDEAD_BEEF_0123_4567, 8'hFF, 2'b00, 64'hDEAD_BEEF_0123_4567});
    tbl.push_back('{TOP,           2'b11, 2'b01, 64'h1234_5678_9ABC_DEF0, 8'hFF, 2'b10, 64'h0});
    tbl.push_back('{BASE + 32'h7,  2'b11, 2'b01, 64'h0123_4567_89AB_CDEF, 8'h80, 2'b00, 64'h0100_0000_0000_0001});
    foreach (tbl[i]) begin
      d = {tbl[i].wdata}; s = {tbl[i].wstrb};
      do_write(tbl[i].addr, 0, tbl[i].size, tbl[i].burst, d, s, 0, 0, 0, bresp);
      check("tbl_bresp", 64'(bresp), 64'(tbl[i].exp_resp));
      model_write(tbl[i].addr, 0, tbl[i].size, tbl[i].burst, d, s);
      do_read(tbl[i].addr, 0, tbl[i].size, tbl[i].burst, 0, rd, rr, rl, first);
      check("tbl_rbeats", 64'(rd.size()), 1);
      if (rd.size() > 0) begin
        check("tbl_rdata", rd[0], tbl[i].exp_rdata);
        check("tbl_rresp", 64'(rr[0]), 64'(tbl[i].exp_resp));
        check("tbl_rlast", 64'(rl[0]), 1);
      end
    end

    // RREADY 1-0-0-1 stalls through an 8-beat read.
    d = {}; s = {};
    for (int i = 0; i < 8; i++) begin d.push_back({$urandom, $urandom}); s.push_back(8'hFF); end
    do_write(BASE + 32'h200, 7, 2'b11, 2'b01, d, s, 7, 0, 0, bresp);
    check("t3_bresp", 64'(bresp), 0);
    model_write(BASE + 32'h200, 7, 2'b11, 2'b01, d, s);
    read_check("t3_rd", BASE + 32'h200, 7, 2'b11, 2'b01, 2);

    // Burst crossing the top of memory, bad size, and an illegal write.
    read_check("t4_top", TOP - 32'h8, 1, 2'b11, 2'b01, 0);
    read_check("t4_size", BASE, 0, 2'b10, 2'b01, 0);
    d = {64'h0, 64'h0}; s = {8'hFF, 8'hFF};
    do_write(TOP - 32'h8, 1, 2'b11, 2'b01, d, s, 1, 0, 0, bresp);
    check("t4_wr_bresp", 64'(bresp), 2);
    read_check("t4_untouched", TOP - 32'h8, 0, 2'b11, 2'b01, 0);

    // Concurrent 16-beat read and write with random handshakes.
    d = {}; s = {}; d2 = {}; s2 = {};
    for (int i = 0; i < 16; i++) begin
      d.push_back({$urandom, $urandom}); s.push_back(8'hFF);
      d2.push_back({$urandom, $urandom}); s2.push_back(8'hFF);
    end
    do_write(BASE + 32'h1000, 15, 2'b11, 2'b01, d, s, 15, 1, 0, bresp);
    check("t5_pre_bresp", 64'(bresp), 0);
    model_write(BASE + 32'h1000, 15, 2'b11, 2'b01, d, s);
    fork
      read_check("t5_conc_rd", BASE + 32'h1000, 15, 2'b11, 2'b01, 1);
      do_write(BASE + 32'h2000, 15, 2'b11, 2'b01, d2, s2, 15, 1, 0, bresp2);
    join
    check("t5_conc_bresp", 64'(bresp2), 0);
    model_write(BASE + 32'h2000, 15, 2'b11, 2'b01, d2, s2);
    read_check("t5_conc_wr_back", BASE + 32'h2000, 15, 2'b11, 2'b01, 1);

    // WLAST early at beat 2, then WLAST never asserted.
    d = {64'h11, 64'h22, 64'h33, 64'h44}; s = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_write(BASE + 32'h3000, 3, 2'b11, 2'b01, d, s, 2, 0, 0, bresp);
    check("t5_early_wlast_bresp", 64'(bresp), 2);
    model_write(BASE + 32'h3000, 3, 2'b11, 2'b01, d, s);
    read_check("t5_early_wlast_rd", BASE + 32'h3000, 3, 2'b11, 2'b01, 0);
    d = {64'h55, 64'h66}; s = {8'hFF, 8'hFF};
    do_write(BASE + 32'h3100, 1, 2'b11, 2'b01, d, s, 99, 0, 0, bresp);
    check("t5_no_wlast_bresp", 64'(bresp), 2);
    model_write(BASE + 32'h3100, 1, 2'b11, 2'b01, d, s);

    // Randomized bursts on a small region, random strobes on known words.
    for (int t = 0; t < 20; t++) begin
      a = BASE + 32'(8 * $urandom_range(0, 63)) + 32'($urandom_range(0, 7));
      len = int'($urandom_range(0, 15));
      d = {}; s = {};
      for (int i = 0; i <= len; i++) begin
        d.push_back({$urandom, $urandom});
        s.push_back(mdl.exists(widx(a) + i) ? 8'($urandom) : 8'hFF);
      end
      do_write(a, len, 2'b11, 2'b01, d, s, len, 1, 0, bresp);
      check("rand_bresp", 64'(bresp), 0);
      model_write(a, len, 2'b11, 2'b01, d, s);
      read_check("rand_rd", a, len, 2'b11, 2'b01, 1);
    end

    // Reset with a write parked in the response phase and a read stalled mid-burst.
    d = {64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0002}; s = {8'hFF, 8'hFF};
    do_write(BASE + 32'h4000, 1, 2'b11, 2'b01, d, s, 1, 0, 1, bresp);
    model_write(BASE + 32'h4000, 1, 2'b11, 2'b01, d, s);
    @(posedge IP_CLK); #1;
    S_ARADDR = BASE; S_ARLEN = 4'd3; S_ARSIZE = 2'b11; S_ARBURST = 2'b01; S_ARVALID = 1'b1;
    S_RREADY = 1'b0;
    n = 0;
    do begin @(negedge IP_CLK); n++; end while (!S_ARREADY && n < BUDGET);
    @(posedge IP_CLK); #1; S_ARVALID = 1'b0;
    n = 0;
    do begin @(negedge IP_CLK); n++; end while (!S_RVALID && n < BUDGET);
    check("t6_pre_rvalid", 64'(S_RVALID), 1);
    check("t6_pre_bvalid", 64'(S_BVALID), 1);
    #2 IP_ARESET_N = 1'b0;
    #1;
    check("t6_rst_rvalid", 64'(S_RVALID), 0);
    check("t6_rst_bvalid", 64'(S_BVALID), 0);
    check("t6_rst_arready", 64'(S_ARREADY), 1);
    check("t6_rst_awready", 64'(S_AWREADY), 1);
    check("t6_rst_wready", 64'(S_WREADY), 0);
    @(negedge IP_CLK); IP_ARESET_N = 1'b1;
    read_check("t6_after_wr", BASE + 32'h4000, 1, 2'b11, 2'b01, 0);
    read_check("t6_after_rd", BASE, 3, 2'b11, 2'b01, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
